// File: rtl/door_release.sv
// Door strike controller: unlock-edge triggered release window, door supervision, saturating unlock count.
// Optional macro FORCED_ENTRY_ALARM_EN: a door opening while LOCKED (without an unlock edge) raises the alarm.
module door_release #(
  parameter int HOLD_CYCLES = 8,
  parameter int OPEN_MAX    = 32,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             unlock0_i,
  input  logic             door_open_i,
  input  logic             ack_i,
  output logic             release_o,
  output logic             alarm_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] unlock_count_o
);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    RELEASED = 2'd1,
    OPEN     = 2'd2,
    ALARM    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] OPEN_LD = CNT_W'(OPEN_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               prev_q;
  logic               release_q, alarm_q;
  logic               unlock_edge;
  logic               count_inc;

  assign unlock_edge = unlock0_i & ~prev_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_inc = 1'b0;
    unique case (state_q)
      LOCKED: begin
        if (unlock_edge) begin
          state_d   = RELEASED;
          timer_d   = HOLD_LD;
          count_inc = 1'b1;
        end
`ifdef FORCED_ENTRY_ALARM_EN
        else if (door_open_i) begin
          state_d = ALARM;
        end
`endif
      end
      RELEASED: begin
        // Door opening wins over a retrigger so the strike drops as soon as the door moves.
        if (door_open_i) begin
          state_d = OPEN;
          timer_d = OPEN_LD;
        end else if (unlock_edge) begin
          timer_d   = HOLD_LD;
          count_inc = 1'b1;
        end else if (timer_q == '0) begin
          state_d = LOCKED;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      OPEN: begin
        if (!door_open_i) begin
          state_d = LOCKED;
        end else if (timer_q == '0) begin
          state_d = ALARM;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ALARM: begin
        if (ack_i && !door_open_i) begin
          state_d = LOCKED;
        end
      end
    endcase
    cnt_d = (count_inc && (cnt_q != CNT_SAT)) ? cnt_q + 1'b1 : cnt_q;
  end

  // Outputs are decoded from the next state so they move together with state_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= LOCKED;
      timer_q   <= '0;
      cnt_q     <= '0;
      prev_q    <= 1'b0;
      release_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      prev_q    <= unlock0_i;
      release_q <= (state_d == RELEASED);
      alarm_q   <= (state_d == ALARM);
    end
  end

  assign release_o      = release_q;
  assign alarm_o        = alarm_q;
  assign state_o        = state_q;
  assign unlock_count_o = cnt_q;

endmodule

// File: tb/tb_door_release.sv
// Bench for door_release: two instances (default and CNT_W=2) checked every cycle against a behavioural model.
module tb_door_release;

  logic       clk;
  logic       rst_n;
  logic       u, d, a;
  logic       release_a, alarm_a, release_b, alarm_b;
  logic [1:0] state_a, state_b;
  logic [7:0] count_a;
  logic [1:0] count_b;

  int checks   = 0;
  int failures = 0;

  door_release #(.HOLD_CYCLES(8), .OPEN_MAX(32), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .unlock0_i(u), .door_open_i(d), .ack_i(a),
    .release_o(release_a), .alarm_o(alarm_a), .state_o(state_a), .unlock_count_o(count_a)
  );

  door_release #(.HOLD_CYCLES(3), .OPEN_MAX(3), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .unlock0_i(u), .door_open_i(d), .ack_i(a),
    .release_o(release_b), .alarm_o(alarm_b), .state_o(state_b), .unlock_count_o(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0 locked, 1 released, 2 open, 3 alarm; release cycles left, open cycles seen.
  int p_hold [2] = '{8, 3};
  int p_omax [2] = '{32, 3};
  int p_cmax [2] = '{255, 3};
  int m_mode [2];
  int m_left [2];
  int m_open [2];
  int m_cnt  [2];
  bit m_prev [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_mode[i] = 0; m_left[i] = 0; m_open[i] = 0; m_cnt[i] = 0; m_prev[i] = 1'b0;
  endtask

  task automatic bump(input int i);
    if (m_cnt[i] < p_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
  endtask

  task automatic model_step(input int i, input bit uu, input bit dd, input bit aa);
    bit e;
    bit fe;
    e = uu && !m_prev[i];
    m_prev[i] = uu;
`ifdef FORCED_ENTRY_ALARM_EN
    fe = 1'b1;
`else
    fe = 1'b0;
`endif
    case (m_mode[i])
      0: if (e) begin m_mode[i] = 1; m_left[i] = p_hold[i]; bump(i); end
         else if (fe && dd) m_mode[i] = 3;
      1: if (dd) begin m_mode[i] = 2; m_open[i] = 0; end
         else if (e) begin m_left[i] = p_hold[i]; bump(i); end
         else if (m_left[i] == 1) m_mode[i] = 0;
         else m_left[i] = m_left[i] - 1;
      2: if (!dd) m_mode[i] = 0;
         else if (m_open[i] == p_omax[i] - 1) m_mode[i] = 3;
         else m_open[i] = m_open[i] + 1;
      default: if (aa && !dd) m_mode[i] = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, u, d, a);
      model_step(1, u, d, a);
    end
    #1;
    check("a_release", release_a, m_mode[0] == 1);
    check("a_alarm",   alarm_a,   m_mode[0] == 3);
    check("a_state",   state_a,   m_mode[0]);
    check("a_count",   count_a,   m_cnt[0]);
    check("b_release", release_b, m_mode[1] == 1);
    check("b_alarm",   alarm_b,   m_mode[1] == 3);
    check("b_state",   state_b,   m_mode[1]);
    check("b_count",   count_b,   m_cnt[1]);
  end

  int n, nb, base;
  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n = 1'b0; u = 1'b0; d = 1'b0; a = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_release", release_a, 0);
    check("rst_state", state_a, 0);
    check("rst_count", count_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic release window
    u = 1'b1; n = 0; nb = 0;
    repeat (12) begin
      @(negedge clk);
      u = 1'b0;
      n += int'(release_a);
      nb += int'(release_b);
    end
    check("basic_release_cycles_a", n, 8);
    check("basic_release_cycles_b", nb, 3);
    check("basic_count", count_a, 1);
    check("basic_state_after", state_a, 0);

    // Held-open alarm
    u = 1'b1;
    @(negedge clk); u = 1'b0;
    @(negedge clk);
    @(negedge clk); d = 1'b1;
    @(negedge clk);
    check("open_release_drop", release_a, 0);
    check("open_state", state_a, 2);
    n = 1;
    while (!alarm_a && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("open_alarm_delay", n, 33);
    check("open_alarm_state", state_a, 3);
    a = 1'b1;
    @(negedge clk); a = 1'b0;
    check("ack_door_open_alarm", alarm_a, 1);
    d = 1'b0;
    @(negedge clk);
    check("closed_no_ack_alarm", alarm_a, 1);
    a = 1'b1;
    @(negedge clk); a = 1'b0;
    check("ack_clear_state", state_a, 0);
    check("ack_clear_alarm", alarm_a, 0);

    // Level hold yields one edge
    base = int'(count_a);
    u = 1'b1;
    repeat (20) @(negedge clk);
    u = 1'b0;
    check("level_hold_count", count_a, base + 1);
    repeat (4) @(negedge clk);

    // Retrigger at release cycle 5
    base = int'(count_a);
    u = 1'b1; n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n += int'(release_a);
      if (i == 1) u = 1'b0;
      if (i == 5) u = 1'b1;
      if (i == 6) u = 1'b0;
    end
    check("retrigger_release_cycles", n, 13);
    check("retrigger_count", count_a, base + 2);

    // Forced entry while locked
    d = 1'b1;
    @(negedge clk);
`ifdef FORCED_ENTRY_ALARM_EN
    check("forced_entry_state", state_a, 3);
`else
    check("forced_entry_state", state_a, 0);
`endif
    d = 1'b0; a = 1'b1;
    @(negedge clk); a = 1'b0;
    check("forced_entry_cleared", state_a, 0);

    // Edge and door together: edge wins
    u = 1'b1; d = 1'b1;
    @(negedge clk);
    check("edge_beats_door", state_a, 1);
    u = 1'b0; d = 1'b0;
    repeat (10) @(negedge clk);

    // Async reset during RELEASED
    u = 1'b1;
    @(negedge clk); u = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("areset_rel_release", release_a, 0);
    check("areset_rel_state", state_a, 0);
    check("areset_rel_count", count_a, 0);
    @(negedge clk); rst_n = 1'b1;

    // Async reset during ALARM
    u = 1'b1;
    @(negedge clk); u = 1'b0;
    @(negedge clk); d = 1'b1;
    repeat (40) @(negedge clk);
    check("pre_areset_alarm", alarm_a, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("areset_alarm_alarm", alarm_a, 0);
    check("areset_alarm_state", state_a, 0);
    check("areset_alarm_count", count_a, 0);
    @(negedge clk); rst_n = 1'b1; d = 1'b0;
    @(negedge clk);

    // Saturation on the 2-bit instance
    for (int k = 0; k < 5; k++) begin
      u = 1'b1;
      @(negedge clk); u = 1'b0;
      check("saturation_count_b", count_b, sat_exp[k]);
      repeat (6) @(negedge clk);
    end

    // Random traffic
    repeat (3000) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      u = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) d = ~d;
      a = ($urandom_range(0, 4) == 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/door_release.md
# door_release

Door-release controller downstream of the `unlock` sequence detector. Consumes its `unlock0` output and drives the door strike (`release`) for a fixed window. Supervises the door sensor afterwards and raises `alarm` on held-open or forced-entry conditions. Keeps a saturating count of accepted unlocks for status readout.

## Interface
- HOLD_CYCLES, 8: cycles `release` stays high after an accepted unlock; legal range 1..2^CNT_W-1.
- OPEN_MAX, 32: cycles the door may stay open before alarm; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the internal timer and of `unlock_count`.
- clk, input, 1: single clock; everything is rising-edge.
- reset, input, 1: asynchronous, active-low reset (asserted at 0).
- unlock0, input, 1: level from `unlock`. Only its 0→1 transition is acted on.
- door_open, input, 1: door sensor, already synchronous to clk; 1 means open.
- ack, input, 1: operator alarm acknowledge.
- release, output, 1: strike drive; registered.
- alarm, output, 1: alarm indication; registered.
- state, output, 2: current FSM state encoding.
- unlock_count, output, CNT_W: saturating count of accepted unlocks.

## Operation
- Edge detect: the `unlock0` value is registered as `prev`. An edge is `unlock0 & ~prev`. While reset is asserted, `prev` is cleared.
- One down-counting timer, CNT_W bits wide, is shared between the RELEASED and OPEN states.
- State LOCKED (2'd0):
  - On an edge, go to RELEASED, load the timer with HOLD_CYCLES-1, and increment `unlock_count`.
  - Otherwise, if `door_open`=1, go to ALARM (forced entry; see Configuration).
  - If an edge and `door_open` occur in the same cycle, the edge wins.
- State RELEASED (2'd1), `release`=1:
  - If `door_open`=1, go to OPEN and load the timer with OPEN_MAX-1. This has priority over a retrigger.
  - Otherwise, on an edge, reload the timer with HOLD_CYCLES-1 and increment the count (retrigger).
  - Otherwise, if the timer is 0, go to LOCKED.
  - Otherwise, decrement the timer.
- State OPEN (2'd2), `release`=0:
  - If `door_open`=0, go to LOCKED.
  - Otherwise, if the timer is 0, go to ALARM.
  - Otherwise, decrement the timer.
  - Edges are ignored and not counted.
- State ALARM (2'd3), `alarm`=1:
  - If `ack`=1 and `door_open`=0 in the same cycle, go to LOCKED.
  - Otherwise, stay. Edges are ignored and not counted.
- Outputs are decoded from the registered next state, so `release`, `alarm` and `state` change in the same cycle.
- `unlock_count` saturates at 2^CNT_W-1; it never wraps.

## Timing
- Reset values: state=LOCKED, `release`=0, `alarm`=0, `unlock_count`=0, timer=0, `prev`=0.
- Reset assertion clears all outputs immediately, with no clock needed, from any state including mid-release and ALARM.
- Latency: if `unlock0` is sampled 1 at edge k (with `prev`=0), `release` is 1 after edge k.
- With the door held closed, `release` stays high for exactly HOLD_CYCLES clock cycles.
- `door_open` sampled 1 at edge k in RELEASED: `release`=0 after edge k.
- OPEN lasting OPEN_MAX+1 sampled cycles with `door_open`=1: `alarm` rises after the (OPEN_MAX+1)th edge.
- `unlock0` held high indefinitely produces one edge only; a new pulse requires a 0 sample first.
- Retrigger: `release` stays continuously high, with no low gap.

## Configuration
- Macro: FORCED_ENTRY_ALARM_EN.
- Defined: LOCKED with `door_open`=1 and no edge goes to ALARM.
- Undefined: `door_open` in LOCKED is ignored and the FSM stays LOCKED. ALARM is then reachable only via the OPEN timeout.

## Test plan
- Basic release (HOLD_CYCLES=8):
  - Stimulus: reset low for 2 cycles, release reset, pulse `unlock0` for 1 cycle, door stays closed.
  - Response: `release` high for exactly 8 cycles, state 1→0, `unlock_count`=1.
- Held-open alarm (OPEN_MAX=32):
  - Stimulus: unlock, raise `door_open` on the 3rd release cycle and hold it.
  - Response: `release` drops the next cycle, `alarm` rises 33 cycles later, state=3.
  - Then pulse `ack` with the door still open: alarm stays. Close the door and pulse `ack`: state 0, `alarm`=0.
- Retrigger plus level hold:
  - Stimulus: hold `unlock0` high for 20 cycles.
  - Response: a single accepted edge, `unlock_count`=1.
  - A second pulse at release cycle 5 gives `unlock_count`=2 and `release` high for 5+8 cycles total.
- Forced entry:
  - Stimulus: `door_open`=1 while LOCKED.
  - Response with FORCED_ENTRY_ALARM_EN: `alarm`=1 the next cycle. Without it: state stays 0.
  - Simultaneous edge plus `door_open`: state=1.
- Saturation with CNT_W=2:
  - Stimulus: 5 separate unlock cycles.
  - Response: `unlock_count` reads 1, 2, 3, 3, 3.
- Async reset mid-operation:
  - Stimulus: assert reset between clock edges during RELEASED, then during ALARM.
  - Response: `release`/`alarm`/`state` go to 0 before the next clk edge, and the count is cleared.
